mul_issue_ctrl: RTL

MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

---
 rtl/mul_issue_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl
//   Issue/writeback controller for a single-cycle-latency multiplier.
//   An EX-stage request is forwarded combinationally to the multiplier
//   (mul_start is the accept strobe). Its destination register is kept in
//   a tag register until mul_done returns one cycle later. The result and
//   tag then go into a small result FIFO that feeds writeback.
//   Issue is credit based: a request is taken only if the FIFO has a slot
//   for it even after counting the result already in flight.
//   Because of that credit rule, the FIFO can never overflow.
//
// Optional feature:
//   `define MUL_WB_BYPASS_EN
//     This enables a same-cycle bypass. When the FIFO is empty, a returning
//     result is presented on wb_* in the cycle it arrives. If wb_ack
//     consumes it in that cycle, it is not written into the FIFO.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           pipeline flush; kills the in-flight op and empties the FIFO
//   req_*           EX-stage request (valid/ready, operands, op, rd)
//   mul_*  (out)    start pulse and operands to the multiplier
//   mul_done/result result return from the multiplier (start + 1 cycle)
//   wb_*            writeback: valid/data/rd out, ack in
module mul_issue_ctrl #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [1:0]  req_op,
  input  logic [4:0]  req_rd,
  output logic        mul_start,
  output logic [31:0] mul_rs1,
  output logic [31:0] mul_rs2,
  output logic [1:0]  mul_op,
  input  logic        mul_done,
  input  logic [31:0] mul_result,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  input  logic        wb_ack
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int CRW = CW + 1;
  localparam logic [CRW-1:0] DEPTH_C = CRW'(FIFO_DEPTH);

  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           inflight_q, inflight_d;
  logic [4:0]     rd_tag_q, rd_tag_d;

  logic [FIFO_DEPTH-1:0][31:0] data_q, data_d;
  logic [FIFO_DEPTH-1:0][4:0]  tag_q, tag_d;

  logic [CRW-1:0] credits;
  logic           accept;
  logic           fifo_empty;
  logic           result_in;
  logic           push;
  logic           pop;

  // Outstanding work = buffered entries + the result that returns next cycle.
  assign credits    = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign fifo_empty = (count_q == '0);

  assign req_ready  = !rst && !flush && (credits < DEPTH_C);
  assign accept     = req_valid && req_ready;

  assign mul_start  = accept;
  assign mul_rs1    = req_rs1;
  assign mul_rs2    = req_rs2;
  assign mul_op     = req_op;

  // A mul_done counts only if its start was issued last cycle and has not
  // been killed since. Stray or killed completions are dropped here.
  assign result_in  = inflight_q && mul_done;

  // A flush cycle ignores wb_ack. The FIFO gets cleared at the edge anyway.
  assign pop        = !fifo_empty && wb_ack && !flush && !rst;

`ifdef MUL_WB_BYPASS_EN
  logic bypass;
  assign bypass   = fifo_empty && result_in && !flush && !rst;
  // A bypassed result consumed in its arrival cycle never occupies a slot.
  assign push     = result_in && !(bypass && wb_ack);
  assign wb_valid = !rst && (!fifo_empty || bypass);
  assign wb_data  = bypass ? mul_result : data_q[rd_ptr_q];
  assign wb_rd    = bypass ? rd_tag_q   : tag_q[rd_ptr_q];
`else
  assign push     = result_in;
  assign wb_valid = !rst && !fifo_empty;
  assign wb_data  = data_q[rd_ptr_q];
  assign wb_rd    = tag_q[rd_ptr_q];
`endif

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    rd_tag_d   = rd_tag_q;
    data_d     = data_q;
    tag_d      = tag_q;

    if (rst) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      inflight_d = 1'b0;
      rd_tag_d   = '0;
    end else if (flush) begin
      // Drop everything that is buffered and the op that is in flight.
      // The tag is left as it is, because nothing will read it until
      // the next accept overwrites it.
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      inflight_d = 1'b0;
    end else begin
      inflight_d = accept;
      if (accept) begin
        rd_tag_d = req_rd;
      end
      if (push) begin
        data_d[wr_ptr_q] = mul_result;
        tag_d[wr_ptr_q]  = rd_tag_q;
        wr_ptr_d         = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    wr_ptr_q   <= wr_ptr_d;
    rd_ptr_q   <= rd_ptr_d;
    count_q    <= count_d;
    inflight_q <= inflight_d;
    rd_tag_q   <= rd_tag_d;
  end

  // Result storage is validated by count_q. It is not reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    tag_q  <= tag_d;
  end

endmodule
